// File: rtl/tdc_analog_model_if.sv
// rtl/tdc_analog_model_if.sv - DCO control inputs and TDC sample outputs of the analog front-end model
interface tdc_analog_model_if #(
  parameter int NPHASES = 16,
  parameter int CNT_W   = 7
);
  logic [31:0]        osc_period_fs;
  logic               pd;
  logic               pd_inj;
  logic [CNT_W-1:0]   ripple_count;
  logic [NPHASES-1:0] phase;

  modport master (
    output osc_period_fs,
    output pd,
    output pd_inj,
    input  ripple_count,
    input  phase
  );

  modport slave (
    input  osc_period_fs,
    input  pd,
    input  pd_inj,
    output ripple_count,
    output phase
  );
endinterface

// File: rtl/tdc_analog_model.sv
// rtl/tdc_analog_model.sv - cycle-based DCO, ripple counter and phase sampler seen from the reference clock
module tdc_analog_model #(
  parameter int REF_PERIOD_FS = 62_500_000,
  parameter int NPHASES       = 16,
  parameter int CNT_W         = 7
) (
  input logic               clk,
  input logic               rst_n,
  tdc_analog_model_if.slave bus
);
  localparam int          IDX_W  = $clog2(NPHASES) + 1;
  localparam logic [63:0] REF_FS = 64'(REF_PERIOD_FS);

  logic [31:0]        phase_acc;
  logic [CNT_W-1:0]   count_q;
  logic [NPHASES-1:0] phase_q;

  logic               advance;
  logic [63:0]        divisor;
  logic [63:0]        acc_clamped;
  logic [63:0]        total;
  logic [63:0]        inc;
  logic [63:0]        idx_w;
  logic [31:0]        acc_next;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   count_next;
  logic [NPHASES-1:0] phase_next;

  always_comb begin
    advance     = !bus.pd && !bus.pd_inj && (bus.osc_period_fs != 32'd0);
    // divisor is forced to 1 when the period is 0 so the hold path never divides by zero
    divisor     = (bus.osc_period_fs == 32'd0) ? 64'd1 : {32'd0, bus.osc_period_fs};
    // clamp keeps a shortened period from seeing more elapsed time than one DCO cycle
    acc_clamped = ({32'd0, phase_acc} < divisor) ? {32'd0, phase_acc} : divisor - 64'd1;
    total       = acc_clamped + REF_FS;
    inc         = total / divisor;
    acc_next    = 32'(total % divisor);
    count_next  = count_q + CNT_W'(inc);
    idx_w       = ({32'd0, acc_next} * 64'(NPHASES)) / divisor;
    idx         = IDX_W'(idx_w);
    phase_next  = '0;
    for (int i = 0; i < NPHASES; i++) begin
      phase_next[i] = (IDX_W'(i) < idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_acc <= '0;
      count_q   <= '0;
      phase_q   <= '0;
    end else if (bus.pd) begin
      phase_acc <= '0;
      count_q   <= '0;
      phase_q   <= '0;
    end else if (advance) begin
      phase_acc <= acc_next;
      count_q   <= count_next;
      phase_q   <= phase_next;
    end
  end

  assign bus.ripple_count = count_q;
  assign bus.phase        = phase_q;
endmodule

// File: tb/tb_tdc_analog_model.sv
// tb/tb_tdc_analog_model.sv - randomized self-checking bench for tdc_analog_model against a time-arithmetic model
module tb_tdc_analog_model;
  localparam longint unsigned REF_FS = 64'd62_500_000;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  longint unsigned m_acc;
  longint unsigned m_cnt;
  logic [15:0]     m_phase;

  tdc_analog_model_if #(.NPHASES(16), .CNT_W(7)) bus ();

  tdc_analog_model #(
    .REF_PERIOD_FS(62_500_000),
    .NPHASES(16),
    .CNT_W(7)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: elapsed DCO time since the last rising edge, advanced by one reference period.
  task automatic model_step(input bit pd, input bit inj, input longint unsigned p);
    longint unsigned elapsed;
    longint unsigned edges;
    longint unsigned frac16;
    if (pd) begin
      m_acc = 0; m_cnt = 0; m_phase = 16'h0000;
    end else if (!inj && p != 0) begin
      elapsed = ((m_acc < p) ? m_acc : p - 1) + REF_FS;
      edges   = elapsed / p;
      m_acc   = elapsed - edges * p;
      m_cnt   = (m_cnt + edges) % 128;
      frac16  = (m_acc * 16) / p;
      m_phase = 16'((32'h1 << frac16) - 32'h1);
    end
  endtask

  task automatic cycle(input bit pd, input bit inj, input longint unsigned p);
    bus.pd            = pd;
    bus.pd_inj        = inj;
    bus.osc_period_fs = 32'(p);
    @(posedge clk);
    #1;
    model_step(pd, inj, p);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle(1'b0, 1'b0, 64'd420003);
    n_checks++;
    if (bus.ripple_count !== 7'd0 || bus.phase !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_initial: count=%0d phase=%h, expected count=0 phase=0000", bus.ripple_count, bus.phase);
    end
    m_acc = 0; m_cnt = 0; m_phase = 16'h0000;
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 64'd420003);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.ripple_count !== 7'd0 || bus.phase !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_async: count=%0d phase=%h, expected count=0 phase=0000", bus.ripple_count, bus.phase);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'($urandom), 1'($urandom), 64'($urandom));
      n_checks++;
      if (bus.ripple_count !== 7'd0 || bus.phase !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: count=%0d phase=%h, expected count=0 phase=0000", i, bus.ripple_count, bus.phase);
      end
    end
    m_acc = 0; m_cnt = 0; m_phase = 16'h0000;
    #3 rst_n = 1'b1;
  endtask

  task automatic test_power_down();
    cycle(1'b0, 1'b0, 64'd420003);
    cycle(1'b0, 1'b0, 64'd420003);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 64'd420003);
      n_checks++;
      if (bus.ripple_count !== 7'd0 || bus.phase !== 16'h0000) begin
        n_fail++;
        $display("FAIL power_down cyc %0d: count=%0d phase=%h, expected count=0 phase=0000", i, bus.ripple_count, bus.phase);
      end
    end
  endtask

  task automatic test_spec_vectors();
    logic [6:0]  exp_cnt [4] = '{7'd20, 7'd41, 7'd15, 7'd31};
    logic [15:0] exp_ph  [4] = '{16'h0FFF, 16'h01FF, 16'h03FF, 16'h000F};
    longint unsigned per [4] = '{64'd420003, 64'd420003, 64'd4000000, 64'd4000000};
    for (int i = 0; i < 4; i++) begin
      if (i == 0 || i == 2) cycle(1'b1, 1'b0, per[i]);
      cycle(1'b0, 1'b0, per[i]);
      n_checks++;
      if (bus.ripple_count !== exp_cnt[i] || bus.phase !== exp_ph[i]) begin
        n_fail++;
        $display("FAIL spec_vector %0d: count=%0d phase=%h, expected count=%0d phase=%h", i, bus.ripple_count, bus.phase, exp_cnt[i], exp_ph[i]);
      end
    end
  endtask

  task automatic test_frozen();
    logic [6:0]  held_cnt;
    logic [15:0] held_ph;
    cycle(1'b1, 1'b0, 64'd420003);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 64'd420003);
    held_cnt = 7'(m_cnt);
    held_ph  = m_phase;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 64'($urandom_range(1, 90_000_000)));
      n_checks++;
      if (bus.ripple_count !== held_cnt || bus.phase !== held_ph) begin
        n_fail++;
        $display("FAIL frozen cyc %0d: count=%0d phase=%h, expected count=%0d phase=%h", i, bus.ripple_count, bus.phase, held_cnt, held_ph);
      end
    end
    cycle(1'b1, 1'b1, 64'd420003);
    n_checks++;
    if (bus.ripple_count !== 7'd0 || bus.phase !== 16'h0000) begin
      n_fail++;
      $display("FAIL pd_over_inj: count=%0d phase=%h, expected count=0 phase=0000", bus.ripple_count, bus.phase);
    end
  endtask

  task automatic test_period_steps();
    longint unsigned steps [7] = '{64'd4000003, 64'd4000004, 64'd4000030, 64'd4000000,
                                   64'd4000016, 64'd50000000, 64'd3000000};
    logic [6:0]  held_cnt;
    logic [15:0] held_ph;
    for (int s = 0; s < 7; s++) begin
      for (int i = 0; i < 3; i++) begin
        cycle(1'b0, 1'b0, steps[s]);
        n_checks++;
        if (bus.ripple_count !== 7'(m_cnt) || bus.phase !== m_phase) begin
          n_fail++;
          $display("FAIL period_step P=%0d cyc %0d: count=%0d phase=%h, expected count=%0d phase=%h", steps[s], i, bus.ripple_count, bus.phase, 7'(m_cnt), m_phase);
        end
      end
    end
    held_cnt = 7'(m_cnt);
    held_ph  = m_phase;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 64'd0);
      n_checks++;
      if (bus.ripple_count !== held_cnt || bus.phase !== held_ph) begin
        n_fail++;
        $display("FAIL zero_period cyc %0d: count=%0d phase=%h, expected count=%0d phase=%h", i, bus.ripple_count, bus.phase, held_cnt, held_ph);
      end
    end
  endtask

  task automatic test_random();
    longint unsigned p;
    int              r;
    bit              pd;
    bit              inj;
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)     p = 0;
      else if (r < 3) p = 64'($urandom_range(1, 2000));
      else            p = 64'($urandom_range(100000, 80_000_000));
      pd  = ($urandom_range(0, 19) == 0);
      inj = ($urandom_range(0, 9) == 0);
      cycle(pd, inj, p);
      n_checks++;
      if (bus.ripple_count !== 7'(m_cnt) || bus.phase !== m_phase) begin
        n_fail++;
        $display("FAIL random cyc %0d P=%0d pd=%0d inj=%0d: count=%0d phase=%h, expected count=%0d phase=%h", i, p, pd, inj, bus.ripple_count, bus.phase, 7'(m_cnt), m_phase);
      end
    end
  endtask

  initial begin
    n_checks          = 0;
    n_fail            = 0;
    m_acc             = 0;
    m_cnt             = 0;
    m_phase           = 16'h0000;
    rst_n             = 1'b0;
    bus.pd            = 1'b0;
    bus.pd_inj        = 1'b0;
    bus.osc_period_fs = 32'd0;
    test_reset();
    test_power_down();
    test_spec_vectors();
    test_frozen();
    test_period_steps();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
